voice_allocator: RTL

- Polyphonic voice scheduler between the MIDI byte parser (after uart_rx) and the per-voice oscillator bank feeding the I2S serialiser.
- Accepts parsed note-on/note-off events and assigns each to one of NUM_VOICES synth voices: retrigger, free-slot and oldest-steal policy.
- Publishes per-voice note, velocity, active flag and a one-cycle trigger pulse for the oscillators.

---
 rtl/audio_pkg.sv | 25 ++
 rtl/voice_slot.sv | 76 +++++++
 rtl/voice_allocator.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the synth datapath: MIDI field widths, MIDI status
// nibbles, the voice allocator FSM encoding and a note-on qualifier helper.
// -----------------------------------------------------------------------------
package audio_pkg;

   localparam int NOTE_W = 7;
   localparam int VEL_W  = 7;

   localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
   localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } alloc_state_t;

   // A note-on with zero velocity is a note-off in running-status MIDI.
   function automatic logic is_note_on(input logic on, input logic [VEL_W-1:0] vel);
      return on && (vel != '0);
   endfunction

endpackage

// File: rtl/voice_slot.sv
// -----------------------------------------------------------------------------
// voice_slot
// State of one synth voice: note, velocity, active flag, saturating age and
// (with SUSTAIN_PEDAL_EN defined) a sustain-held flag.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr                load note_in/vel_in, set active, zero age, pulse trig
//   clr               clear active (and held)
//   hold              (SUSTAIN_PEDAL_EN) mark voice as held by the pedal
//   age_inc           increment age, saturating at all-ones
//   note_in, vel_in   values loaded on wr
//   active, note, vel, age, held   current slot state
//   trig              one-cycle pulse in the cycle after wr
// -----------------------------------------------------------------------------
module voice_slot
   import audio_pkg::*;
#(
   parameter int AGE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic              clr,
`ifdef SUSTAIN_PEDAL_EN
   input  logic              hold,
   output logic              held,
`endif
   input  logic              age_inc,
   input  logic [NOTE_W-1:0] note_in,
   input  logic [VEL_W-1:0]  vel_in,
   output logic              active,
   output logic [NOTE_W-1:0] note,
   output logic [VEL_W-1:0]  vel,
   output logic [AGE_W-1:0]  age,
   output logic              trig
);

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         note   <= '0;
         vel    <= '0;
         age    <= '0;
         trig   <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
         held   <= 1'b0;
`endif
      end else begin
         trig <= wr;
         if (wr) begin
            note   <= note_in;
            vel    <= vel_in;
            active <= 1'b1;
            age    <= '0;
`ifdef SUSTAIN_PEDAL_EN
            held   <= 1'b0;
`endif
         end else if (clr) begin
            // note/vel are kept so the oscillator release tail keeps its pitch
            active <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
            held   <= 1'b0;
`endif
         end
`ifdef SUSTAIN_PEDAL_EN
         else if (hold) begin
            held <= 1'b1;
         end
`endif
         else if (age_inc && (age != '1)) begin
            age <= age + 1'b1;
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Assigns parsed MIDI note-on/off events to NUM_VOICES voice slots using a
// retrigger / lowest-free / oldest-steal policy. One voice is examined per
// cycle, so every event takes a fixed NUM_VOICES+2 cycles.
// Optional feature macro: SUSTAIN_PEDAL_EN (adds ev_sustain and held voices).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ev_valid / ev_ready      event handshake (ready only in IDLE)
//   ev_on, ev_note, ev_vel   event fields, latched on acceptance
//   ev_sustain               (SUSTAIN_PEDAL_EN) sustain pedal level
//   voice_active             per-voice sounding flag
//   voice_note, voice_vel    per-voice note/velocity, voice v at [7v+6:7v]
//   voice_trig               one-cycle pulse on (re)assignment of voice v
// -----------------------------------------------------------------------------
module voice_allocator
   import audio_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ev_valid,
   output logic                         ev_ready,
   input  logic                         ev_on,
   input  logic [NOTE_W-1:0]            ev_note,
   input  logic [VEL_W-1:0]             ev_vel,
`ifdef SUSTAIN_PEDAL_EN
   input  logic                         ev_sustain,
`endif
   output logic [NUM_VOICES-1:0]        voice_active,
   output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
   output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
   output logic [NUM_VOICES-1:0]        voice_trig
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   alloc_state_t      state;
   logic [IDX_W-1:0]  idx;
   logic              ready_r;
   logic              ready_go;
   logic              last;

   logic              lat_on;
   logic [NOTE_W-1:0] lat_note;
   logic [VEL_W-1:0]  lat_vel;

   // running scan results (registered) and their updated versions (n_*)
   logic              match_f, free_f, old_f;
   logic [IDX_W-1:0]  match_i, free_i, old_i;
   logic [AGE_W-1:0]  old_age;
   logic              n_match_f, n_free_f, n_old_f;
   logic [IDX_W-1:0]  n_match_i, n_free_i, n_old_i;
   logic [AGE_W-1:0]  n_old_age;

   logic [NOTE_W-1:0] note_a [NUM_VOICES];
   logic [AGE_W-1:0]  age_a  [NUM_VOICES];
   logic              cur_act;
   logic [NOTE_W-1:0] cur_note;
   logic [AGE_W-1:0]  cur_age;

   logic [IDX_W-1:0]      tgt;
   logic [NUM_VOICES-1:0] wr_v, clr_v, inc_v;

`ifdef SUSTAIN_PEDAL_EN
   logic                  lat_sus, sus_prev, rel_pend, rel_pend_nx, fall;
   logic                  held_f, n_held_f;
   logic [IDX_W-1:0]      held_i, n_held_i;
   logic [AGE_W-1:0]      held_age, n_held_age;
   logic [NUM_VOICES-1:0] held_v, hold_v;
   logic                  cur_held;

   assign cur_held = held_v[idx];
   assign fall     = sus_prev & ~ev_sustain;
   // A pedal release is applied as a dedicated IDLE cycle; if it arrives
   // mid-event it waits until the FSM is back in IDLE.
   assign rel_pend_nx = (state == IDLE && rel_pend) ? fall : (rel_pend | fall);
   assign ready_go    = ~rel_pend_nx;
`else
   assign ready_go    = 1'b1;
`endif

   assign ev_ready = ready_r;
   assign last     = (idx == LAST_IDX);
   assign cur_act  = voice_active[idx];
   assign cur_note = note_a[idx];
   assign cur_age  = age_a[idx];

   // Fold the voice under examination into the running scan results.
   always_comb begin
      n_match_f = match_f;
      n_match_i = match_i;
      n_free_f  = free_f;
      n_free_i  = free_i;
      n_old_f   = old_f;
      n_old_i   = old_i;
      n_old_age = old_age;
      if (!match_f && cur_act && (cur_note == lat_note)) begin
         n_match_f = 1'b1;
         n_match_i = idx;
      end
      if (!free_f && !cur_act) begin
         n_free_f = 1'b1;
         n_free_i = idx;
      end
      // strict '>' keeps the lowest index on equal ages
      if (cur_act && (!old_f || (cur_age > old_age))) begin
         n_old_f   = 1'b1;
         n_old_i   = idx;
         n_old_age = cur_age;
      end
`ifdef SUSTAIN_PEDAL_EN
      n_held_f   = held_f;
      n_held_i   = held_i;
      n_held_age = held_age;
      if (cur_act && cur_held && (!held_f || (cur_age > held_age))) begin
         n_held_f   = 1'b1;
         n_held_i   = idx;
         n_held_age = cur_age;
      end
`endif
   end

   // Slot update decision, taken in the last SCAN cycle so the slot registers
   // (and voice_trig) change on the edge into COMMIT.
   always_comb begin
      wr_v  = '0;
      clr_v = '0;
      inc_v = '0;
`ifdef SUSTAIN_PEDAL_EN
      hold_v = '0;
`endif
      if (n_match_f)     tgt = n_match_i;
      else if (n_free_f) tgt = n_free_i;
`ifdef SUSTAIN_PEDAL_EN
      else if (n_held_f) tgt = n_held_i;
`endif
      else               tgt = n_old_i;

      if (state == SCAN && last) begin
         if (lat_on) begin
            wr_v[tgt] = 1'b1;
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (voice_active[v] && (IDX_W'(v) != tgt)) inc_v[v] = 1'b1;
            end
         end else if (n_match_f) begin
`ifdef SUSTAIN_PEDAL_EN
            if (lat_sus) hold_v[n_match_i] = 1'b1;
            else         clr_v[n_match_i]  = 1'b1;
`else
            clr_v[n_match_i] = 1'b1;
`endif
         end
      end
`ifdef SUSTAIN_PEDAL_EN
      if (state == IDLE && rel_pend) clr_v = held_v;
`endif
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
      voice_slot #(.AGE_W(AGE_W)) u_slot (
         .clk     (clk),
         .rst     (rst),
         .wr      (wr_v[g]),
         .clr     (clr_v[g]),
`ifdef SUSTAIN_PEDAL_EN
         .hold    (hold_v[g]),
         .held    (held_v[g]),
`endif
         .age_inc (inc_v[g]),
         .note_in (lat_note),
         .vel_in  (lat_vel),
         .active  (voice_active[g]),
         .note    (voice_note[g*NOTE_W +: NOTE_W]),
         .vel     (voice_vel[g*VEL_W +: VEL_W]),
         .age     (age_a[g]),
         .trig    (voice_trig[g])
      );
      assign note_a[g] = voice_note[g*NOTE_W +: NOTE_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         ready_r  <= 1'b0;
         lat_on   <= 1'b0;
         lat_note <= '0;
         lat_vel  <= '0;
         match_f  <= 1'b0;
         match_i  <= '0;
         free_f   <= 1'b0;
         free_i   <= '0;
         old_f    <= 1'b0;
         old_i    <= '0;
         old_age  <= '0;
`ifdef SUSTAIN_PEDAL_EN
         lat_sus  <= 1'b0;
         sus_prev <= 1'b0;
         rel_pend <= 1'b0;
         held_f   <= 1'b0;
         held_i   <= '0;
         held_age <= '0;
`endif
      end else begin
`ifdef SUSTAIN_PEDAL_EN
         sus_prev <= ev_sustain;
         rel_pend <= rel_pend_nx;
`endif
         case (state)
            IDLE: begin
               if (ev_valid && ready_r) begin
                  state    <= SCAN;
                  idx      <= '0;
                  ready_r  <= 1'b0;
                  lat_on   <= is_note_on(ev_on, ev_vel);
                  lat_note <= ev_note;
                  lat_vel  <= ev_vel;
                  match_f  <= 1'b0;
                  free_f   <= 1'b0;
                  old_f    <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
                  lat_sus  <= ev_sustain;
                  held_f   <= 1'b0;
`endif
               end else begin
                  ready_r <= ready_go;
               end
            end
            SCAN: begin
               match_f <= n_match_f;
               match_i <= n_match_i;
               free_f  <= n_free_f;
               free_i  <= n_free_i;
               old_f   <= n_old_f;
               old_i   <= n_old_i;
               old_age <= n_old_age;
`ifdef SUSTAIN_PEDAL_EN
               held_f   <= n_held_f;
               held_i   <= n_held_i;
               held_age <= n_held_age;
`endif
               if (last) state <= COMMIT;
               else      idx   <= idx + 1'b1;
            end
            COMMIT: begin
               state   <= IDLE;
               ready_r <= ready_go;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
